// File: rtl/seg_result_scan.sv
// rtl/seg_result_scan.sv - multiplexed 4-digit seven-segment display of an add/subtract result
// Latches sum/carry/overflow/mode on load and scans one active-low digit per REFRESH_DIV cycles.
module seg_result_scan #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] s,
  input  logic       cout,
  input  logic       v,
  input  logic       m,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       err
);

  localparam logic [15:0] CNT_MAX   = 16'(REFRESH_DIV - 1);
  localparam logic [3:0]  SYM_DASH  = 4'd10;
  localparam logic [3:0]  SYM_E     = 4'd11;
  localparam logic [3:0]  SYM_BLANK = 4'd15;

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  s_q, s_d;
  logic        cout_q, cout_d;
  logic        v_q, v_d;
  logic        m_q, m_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        err_q, err_d;

  logic [4:0]  value;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic [3:0]  mag;
  logic [3:0]  sym0, sym1, sym2, sym3;
  logic [3:0]  sym_sel;

  function automatic logic [6:0] seg_code(input logic [3:0] sym);
    logic [6:0] code;
    case (sym)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      4'd10:   code = 7'b0111111;
      4'd11:   code = 7'b0000110;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      m_q    <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      v_q    <= v_d;
      m_q    <= m_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    v_d    = v_q;
    m_d    = m_q;
    if (load) begin
      s_d    = s;
      cout_d = cout;
      v_d    = v;
      m_d    = m;
    end
  end

  // Unsigned value split into decimal digits; signed value reduced to magnitude.
  always_comb begin
    value = {cout_q, s_q};
    tens  = 4'd0;
    units = value[3:0];
    if (value >= 5'd30) begin
      tens  = 4'd3;
      units = 4'(value - 5'd30);
    end else if (value >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(value - 5'd20);
    end else if (value >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(value - 5'd10);
    end
    mag = s_q[3] ? (~s_q + 4'd1) : s_q;
  end

  always_comb begin
    sym0 = SYM_BLANK;
    sym1 = SYM_BLANK;
    sym2 = SYM_BLANK;
    sym3 = SYM_BLANK;
    if (!m_q) begin
      sym0 = units;
      sym1 = (tens == 4'd0) ? SYM_BLANK : tens;
    end else if (!v_q) begin
      sym0 = mag;
      sym2 = s_q[3] ? SYM_DASH : SYM_BLANK;
    end else begin
      sym3 = SYM_E;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    sym_sel = sym0;
      2'd1:    sym_sel = sym1;
      2'd2:    sym_sel = sym2;
      default: sym_sel = sym3;
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_code(sym_sel);
    err_d = m_q & v_q;
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_seg_result_scan.sv
// tb/tb_seg_result_scan.sv - scoreboard bench for seg_result_scan
// Stimulus pushes the expected {an,seg,err} of each edge; a monitor pops and checks on the falling edge.
module tb_seg_result_scan;

  localparam int DIV = 4;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] CD = 7'b0111111;
  localparam logic [6:0] CE = 7'b0000110;
  localparam logic [6:0] CB = 7'b1111111;

  typedef struct packed {
    logic [3:0] s;
    logic       co;
    logic       v;
    logic       m;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
    logic       e;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] s;
  logic       cout;
  logic       v;
  logic       m;
  logic [3:0] an;
  logic [6:0] seg;
  logic       err;

  exp_t       expq[$];
  int         n_checks;
  int         n_fail;
  int         tb_cnt;
  int         tb_idx;
  logic [6:0] disp[4];
  logic       cur_err;
  int         cyc_no;

  seg_result_scan #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .s    (s),
    .cout (cout),
    .v    (v),
    .m    (m),
    .an   (an),
    .seg  (seg),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] fs, input logic fco, input logic fv, input logic fm,
                              input logic [6:0] f3, input logic [6:0] f2, input logic [6:0] f1,
                              input logic [6:0] f0, input logic fe);
    vec_t r;
    r.s = fs; r.co = fco; r.v = fv; r.m = fm;
    r.d3 = f3; r.d2 = f2; r.d1 = f1; r.d0 = f0; r.e = fe;
    return r;
  endfunction

  // One clock: drive on the falling edge, record what the rising edge must produce.
  task automatic cyc(input logic r, input logic ld, input vec_t vc);
    exp_t e;
    @(negedge clk);
    rst  = r;
    load = ld;
    s    = vc.s;
    cout = vc.co;
    v    = vc.v;
    m    = vc.m;
    if (r) begin
      e.an = 4'b1111; e.seg = CB; e.err = 1'b0;
    end else begin
      e.an = ~(4'b0001 << tb_idx); e.seg = disp[tb_idx]; e.err = cur_err;
    end
    @(posedge clk);
    expq.push_back(e);
    if (r) begin
      tb_cnt = 0; tb_idx = 0; cur_err = 1'b0;
      disp[0] = C0; disp[1] = CB; disp[2] = CB; disp[3] = CB;
    end else begin
      if (ld) begin
        disp[0] = vc.d0; disp[1] = vc.d1; disp[2] = vc.d2; disp[3] = vc.d3;
        cur_err = vc.e;
      end
      if (tb_cnt == DIV - 1) begin
        tb_cnt = 0;
        tb_idx = (tb_idx + 1) % 4;
      end else begin
        tb_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    vec_t z;
    z = mk(4'd0, 1'b0, 1'b0, 1'b0, CB, CB, CB, CB, 1'b0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, z);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      cyc_no++;
      if ({an, seg, err} !== {e.an, e.seg, e.err}) begin
        n_fail++;
        $display("FAIL scan_out#%0d: got an=%b seg=%b err=%b, expected an=%b seg=%b err=%b",
                 cyc_no, an, seg, err, e.an, e.seg, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vec_t ve, v5;
    n_checks = 0; n_fail = 0; cyc_no = 0;
    tb_cnt = 0; tb_idx = 0; cur_err = 1'b0;
    disp[0] = C0; disp[1] = CB; disp[2] = CB; disp[3] = CB;
    rst = 1'b1; load = 1'b0; s = 4'd0; cout = 1'b0; v = 1'b0; m = 1'b0;

    vecs[0] = mk(4'b1011, 1'b1, 1'b0, 1'b0, CB, CB, C2, C7, 1'b0); // 27
    vecs[1] = mk(4'b1110, 1'b0, 1'b0, 1'b0, CB, CB, C1, C4, 1'b0); // 14
    vecs[2] = mk(4'b1111, 1'b1, 1'b0, 1'b0, CB, CB, C3, C1, 1'b0); // 31
    vecs[3] = mk(4'b1001, 1'b0, 1'b1, 1'b0, CB, CB, CB, C9, 1'b0); // 9, v ignored in add mode
    vecs[4] = mk(4'b1101, 1'b1, 1'b0, 1'b1, CB, CD, CB, C3, 1'b0); // -3, cout ignored
    vecs[5] = mk(4'b1000, 1'b0, 1'b0, 1'b1, CB, CD, CB, C8, 1'b0); // -8
    vecs[6] = mk(4'b0111, 1'b0, 1'b0, 1'b1, CB, CB, CB, C7, 1'b0); // +7
    vecs[7] = mk(4'b0110, 1'b0, 1'b1, 1'b1, CE, CB, CB, CB, 1'b1); // overflow
    ve = vecs[7];
    v5 = mk(4'b0101, 1'b0, 1'b0, 1'b0, CB, CB, CB, C5, 1'b0);

    cyc(1'b1, 1'b0, vecs[0]);
    cyc(1'b1, 1'b1, vecs[0]);
    idle(17);

    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, vecs[k]);
      idle(16);
    end

    // Reset while digit 2 is lit, with load held and overflow data pending.
    for (int i = 0; i < 20 && tb_idx != 2; i++) idle(1);
    cyc(1'b1, 1'b1, ve);
    idle(17);

    // Load exactly on the digit 0 -> 1 transition edge.
    for (int i = 0; i < 20 && !(tb_idx == 0 && tb_cnt == DIV - 1); i++) idle(1);
    cyc(1'b0, 1'b1, v5);
    idle(17);

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
